// File: rtl/conv_ctrl.sv
// rtl/conv_ctrl.sv - 3x3 convolution window controller feeding an external conv_pe
// Optional ReLU on feat_out when CONV_CTRL_RELU_EN is defined.
module conv_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PE_LAT = 3
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               w_wr,
  input  logic signed [15:0] w_data,
  input  logic signed [15:0] pix_in,
  input  logic               pix_va,
  output logic               pix_rdy,
  output logic signed [15:0] w00,
  output logic signed [15:0] w01,
  output logic signed [15:0] w02,
  output logic signed [15:0] w10,
  output logic signed [15:0] w11,
  output logic signed [15:0] w12,
  output logic signed [15:0] w20,
  output logic signed [15:0] w21,
  output logic signed [15:0] w22,
  output logic signed [15:0] row0_in,
  output logic signed [15:0] row1_in,
  output logic signed [15:0] row2_in,
  output logic               pe_en,
  input  logic signed [15:0] map_out,
  output logic               feat_va,
  output logic signed [15:0] feat_out,
  output logic               frame_done,
  output logic               busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = $clog2(PE_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept, last_col, last_pix, drain_end;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [DW-1:0]      drain_cnt;
  logic [3:0]         w_idx;
  logic signed [15:0] w_r    [9];
  logic signed [15:0] line_a [IMG_W];
  logic signed [15:0] line_b [IMG_W];
  logic               tag_in, pe_en_d;
  logic [PE_LAT-1:0]  tag_pipe;

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = (state == RUN) && pix_va;
    last_col   = (x == XW'(IMG_W - 1));
    last_pix   = last_col && (y == YW'(IMG_H - 1));
    drain_end  = (drain_cnt == DW'(PE_LAT));
    pix_rdy    = (state == RUN);
    busy       = (state == RUN) || (state == DRAIN);
    frame_done = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      w_idx <= '0;
      for (int i = 0; i < 9; i++) w_r[i] <= '0;
    end else if (state == IDLE) begin
      if (w_wr) w_r[w_idx] <= w_data;
      if (start)     w_idx <= '0;
      else if (w_wr) w_idx <= (w_idx == 4'd8) ? 4'd0 : w_idx + 4'd1;
    end
  end

  assign w00 = w_r[0];
  assign w01 = w_r[1];
  assign w02 = w_r[2];
  assign w10 = w_r[3];
  assign w11 = w_r[4];
  assign w12 = w_r[5];
  assign w20 = w_r[6];
  assign w21 = w_r[7];
  assign w22 = w_r[8];

  // Line buffers carry no reset: the first two lines of a frame are never tagged.
  always_ff @(posedge pclk) begin
    if (accept) begin
      line_b[x] <= pix_in;
      line_a[x] <= line_b[x];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      drain_cnt <= '0;
      row0_in   <= '0;
      row1_in   <= '0;
      row2_in   <= '0;
      tag_in    <= 1'b0;
      pe_en     <= 1'b0;
      pe_en_d   <= 1'b0;
      tag_pipe  <= '0;
    end else begin
      pe_en   <= 1'b0;
      pe_en_d <= pe_en;
      if (accept) begin
        row2_in <= pix_in;
        row1_in <= line_b[x];
        row0_in <= line_a[x];
        tag_in  <= (x >= XW'(2)) && (y >= YW'(2));
        pe_en   <= 1'b1;
        if (last_col) begin
          x <= '0;
          y <= last_pix ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      // Zero columns flush the final real column out of conv_pe.
      if (state == DRAIN) begin
        if (!drain_end) begin
          row0_in   <= '0;
          row1_in   <= '0;
          row2_in   <= '0;
          tag_in    <= 1'b0;
          pe_en     <= 1'b1;
          drain_cnt <= drain_cnt + 1'b1;
        end
      end else begin
        drain_cnt <= '0;
      end
      if (pe_en) begin
        tag_pipe[0] <= tag_in;
        for (int k = 1; k < PE_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // map_out lines up with the exiting tag in the cycle right after a pe_en step.
  always_comb begin
    feat_va  = pe_en_d && tag_pipe[PE_LAT-1];
    feat_out = '0;
    if (feat_va) begin
`ifdef CONV_CTRL_RELU_EN
      feat_out = map_out[15] ? 16'sd0 : map_out;
`else
      feat_out = map_out;
`endif
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// tb/tb_conv_ctrl.sv - scoreboard bench for conv_ctrl with a behavioural conv_pe
module tb_conv_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int LAT = 3;

  logic               pclk = 1'b0;
  logic               rst, start, w_wr, pix_va;
  logic signed [15:0] w_data, pix_in;
  logic               pix_rdy, pe_en, feat_va, frame_done, busy;
  logic signed [15:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic signed [15:0] row0_in, row1_in, row2_in, map_out, feat_out;

  conv_ctrl #(.IMG_W(W), .IMG_H(H), .PE_LAT(LAT)) dut (
    .pclk(pclk), .rst(rst), .start(start), .w_wr(w_wr), .w_data(w_data),
    .pix_in(pix_in), .pix_va(pix_va), .pix_rdy(pix_rdy),
    .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in), .pe_en(pe_en),
    .map_out(map_out), .feat_va(feat_va), .feat_out(feat_out),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  int n_feat = 0;
  int n_done = 0;
  int pe_err = 0;
  bit chk_pe = 0;
  bit prev_rdy = 0;
  bit prev_acc = 0;

  logic signed [15:0] img [W*H];
  logic signed [15:0] wt  [9];
  logic signed [15:0] exp_q [$];
  logic signed [15:0] mon_e;

  // conv_pe model: three-column window, PE_LAT result stages, steps only on pe_en.
  logic signed [15:0] wv [9];
  logic signed [15:0] c1 [3];
  logic signed [15:0] c2 [3];
  logic signed [15:0] stg [LAT];

  always_comb begin
    wv[0] = w00; wv[1] = w01; wv[2] = w02;
    wv[3] = w10; wv[4] = w11; wv[5] = w12;
    wv[6] = w20; wv[7] = w21; wv[8] = w22;
  end

  function automatic logic signed [15:0] pe_sum();
    int acc;
    logic signed [15:0] nc [3];
    nc[0] = row0_in; nc[1] = row1_in; nc[2] = row2_in;
    acc = 0;
    for (int i = 0; i < 3; i++)
      acc += int'(wv[i*3]) * int'(c1[i]) + int'(wv[i*3+1]) * int'(c2[i])
           + int'(wv[i*3+2]) * int'(nc[i]);
    return 16'(acc);
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin c1[i] <= '0; c2[i] <= '0; end
      for (int k = 0; k < LAT; k++) stg[k] <= '0;
    end else if (pe_en) begin
      stg[0] <= pe_sum();
      for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
      c1[0] <= c2[0]; c1[1] <= c2[1]; c1[2] <= c2[2];
      c2[0] <= row0_in; c2[1] <= row1_in; c2[2] <= row2_in;
    end
  end
  assign map_out = stg[LAT-1];

  function automatic logic signed [15:0] ref_conv(input int x, input int y);
    int acc;
    logic signed [15:0] r;
    acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(wt[i*3+j]) * int'(img[(y-2+i)*W + (x-2+j)]);
    r = 16'(acc);
`ifdef CONV_CTRL_RELU_EN
    if (r < 0) r = 16'sd0;
`endif
    return r;
  endfunction

  always @(negedge pclk) begin
    if (!rst) begin
      if (feat_va) begin
        n_feat++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL feature_unexpected: got %0d, none expected", feat_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (feat_out !== mon_e) begin
            n_err++;
            $display("FAIL feature_value: got %0d, expected %0d", feat_out, mon_e);
          end
        end
      end
      if (frame_done) begin
        n_done++;
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL done_before_features: %0d features outstanding, expected 0", exp_q.size());
        end
      end
      if (chk_pe && prev_rdy && pe_en !== prev_acc) pe_err++;
    end
    prev_rdy = pix_rdy;
    prev_acc = pix_va && pix_rdy;
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic load_wt();
    for (int i = 0; i < 9; i++) begin
      w_wr = 1'b1; w_data = wt[i]; tick();
    end
    w_wr = 1'b0;
  endtask

  task automatic set_img(input bit raster);
    for (int i = 0; i < W*H; i++) img[i] = raster ? 16'(i) : 16'sd1;
  endtask

  task automatic set_wt_center(input logic signed [15:0] c, input logic signed [15:0] others);
    for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? c : others;
  endtask

  task automatic drive_frame(input bit gap, input int npix, input bit poke, output bit timeout);
    int n;
    int cyc;
    bit tog;
    n = 0; cyc = 0; tog = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    while (n < npix && cyc < 500) begin
      pix_va = gap ? tog : 1'b1;
      tog = ~tog;
      pix_in = img[n];
      w_wr   = poke && n == 5;
      start  = poke && n == 5;
      w_data = 16'sh55;
      @(negedge pclk);
      if (pix_va && pix_rdy) begin
        if (n % W >= 2 && n / W >= 2) exp_q.push_back(ref_conv(n % W, n / W));
        n++;
      end
      tick();
      cyc++;
    end
    pix_va = 1'b0; w_wr = 1'b0; start = 1'b0;
    timeout = (cyc >= 500);
  endtask

  task automatic wait_done(output bit ok);
    int c;
    int d0;
    c = 0; d0 = n_done;
    while (n_done == d0 && c < 100) begin tick(); c++; end
    ok = (n_done != d0);
    repeat (3) tick();
  endtask

  task automatic full_frame(input string name, input bit gap, input bit poke);
    bit to;
    bit ok;
    int f0;
    int d0;
    f0 = n_feat; d0 = n_done;
    drive_frame(gap, W*H, poke, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL %s_accept_timeout: pixels not accepted in budget", name); end
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_done: frame_done not seen, expected one pulse", name); end
    n_cmp++;
    if (n_feat - f0 !== (W-2)*(H-2)) begin
      n_err++; $display("FAIL %s_count: got %0d features, expected %0d", name, n_feat - f0, (W-2)*(H-2));
    end
    n_cmp++;
    if (n_done - d0 !== 1) begin
      n_err++; $display("FAIL %s_done_count: got %0d pulses, expected 1", name, n_done - d0);
    end
    n_cmp++;
    if ({busy, pix_rdy, pe_en} !== 3'b000) begin
      n_err++; $display("FAIL %s_idle: busy/pix_rdy/pe_en = %b, expected 000", name, {busy, pix_rdy, pe_en});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; w_wr = 0; w_data = 0; pix_in = 0; pix_va = 0;
    repeat (3) tick();
    @(negedge pclk);
    n_cmp++;
    if ({pix_rdy, pe_en, feat_va, frame_done, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, expected 00000", {pix_rdy, pe_en, feat_va, frame_done, busy});
    end
    n_cmp++;
    if ({row0_in, row1_in, row2_in} !== 48'b0) begin
      n_err++; $display("FAIL reset_rows: got %h, expected 0", {row0_in, row1_in, row2_in});
    end
    n_cmp++;
    if (feat_out !== 16'sd0) begin n_err++; $display("FAIL reset_feat_out: got %0d, expected 0", feat_out); end
    n_cmp++;
    if ({w00, w01, w02, w10, w11, w12, w20, w21, w22} !== 144'b0) begin
      n_err++; $display("FAIL reset_weights: got nonzero, expected all 0");
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_weight_wrap();
    for (int i = 0; i < 9; i++) wt[i] = 16'(i + 1);
    load_wt();
    w_wr = 1'b1; w_data = 16'sd7; tick(); w_wr = 1'b0;
    @(negedge pclk);
    n_cmp++;
    if (w00 !== 16'sd7) begin n_err++; $display("FAIL wrap_w00: got %0d, expected 7", w00); end
    n_cmp++;
    if (w01 !== 16'sd2) begin n_err++; $display("FAIL wrap_w01: got %0d, expected 2", w01); end
    n_cmp++;
    if (w22 !== 16'sd9) begin n_err++; $display("FAIL wrap_w22: got %0d, expected 9", w22); end
    tick();
    for (int i = 1; i < 9; i++) begin w_wr = 1'b1; w_data = -16'sd3; tick(); end
    w_wr = 1'b0;
    @(negedge pclk);
    n_cmp++;
    if (w01 !== -16'sd3 || w00 !== 16'sd7) begin
      n_err++; $display("FAIL wrap_refill: w00=%0d w01=%0d, expected 7 and -3", w00, w01);
    end
    tick();
  endtask

  task automatic test_all_ones();
    set_img(0); set_wt_center(16'sd1, 16'sd1); load_wt();
    full_frame("ones", 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    set_img(0); set_wt_center(16'sd1, 16'sd1); load_wt();
    pe_err = 0; chk_pe = 1'b1;
    full_frame("gaps", 1'b1, 1'b0);
    chk_pe = 1'b0;
    n_cmp++;
    if (pe_err !== 0) begin n_err++; $display("FAIL gaps_pe_en: %0d bad cycles, expected 0", pe_err); end
  endtask

  task automatic test_raster();
    set_img(1); set_wt_center(16'sd1, 16'sd0); load_wt();
    full_frame("raster", 1'b0, 1'b0);
  endtask

  task automatic test_negative();
    set_img(0); set_wt_center(-16'sd1, 16'sd0); load_wt();
    full_frame("negative", 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    bit to;
    int d0;
    set_img(0); set_wt_center(16'sd1, 16'sd1); load_wt();
    drive_frame(1'b0, 7, 1'b0, to);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    exp_q.delete();
    @(negedge pclk);
    n_cmp++;
    if ({busy, pix_rdy} !== 2'b00 || w11 !== 16'sd0) begin
      n_err++; $display("FAIL abort_state: busy/pix_rdy=%b w11=%0d, expected 00 and 0", {busy, pix_rdy}, w11);
    end
    d0 = n_done;
    repeat (20) tick();
    n_cmp++;
    if (n_done !== d0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses, expected 0", n_done - d0); end
    load_wt();
    full_frame("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignores();
    set_img(1); set_wt_center(16'sd1, 16'sd1); load_wt();
    full_frame("busy", 1'b0, 1'b1);
    n_cmp++;
    if ({w00, w01, w02, w10, w11, w12, w20, w21, w22} !== {9{16'sd1}}) begin
      n_err++; $display("FAIL busy_weights: w00=%0d w11=%0d, expected all 1", w00, w11);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_weight_wrap();
    test_all_ones();
    test_gaps();
    test_raster();
    test_negative();
    test_abort();
    test_busy_ignores();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameters: IMG_W, default 32, image width in pixels (>=3); IMG_H, default 32, image height in lines (>=3); PE_LAT, default 3, conv_pe result latency in pe_en-high cycles.
REQ-002 pclk  input  1  clock; single clock domain.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a frame when idle.
REQ-005 w_wr, w_data  input  1 / 16 signed  serial weight load, order w00,w01,w02,w10,...,w22.
REQ-006 pix_in, pix_va  input  16 signed / 1  raster pixel stream.
REQ-007 pix_rdy  output  1  pixel accept; transfer when pix_va && pix_rdy.
REQ-008 w00..w22  output  16 signed each  registered weights driving conv_pe.
REQ-009 row0_in, row1_in, row2_in  output  16 signed each  column (y-2, y-1, y) of the window.
REQ-010 pe_en  output  1  conv_pe enable.
REQ-011 map_out  input  16 signed  conv_pe result.
REQ-012 feat_va, feat_out  output  1 / 16 signed  valid output feature.
REQ-013 frame_done, busy  output  1 / 1  end-of-frame pulse; frame in progress.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on start; RUN->DRAIN after pixel IMG_W*IMG_H-1 is accepted; DRAIN->DONE after PE_LAT drain cycles; DONE->IDLE after exactly one cycle.
REQ-016 start is ignored outside IDLE.
REQ-017 w_wr is accepted only in IDLE; 4-bit index advances 0..8 and wraps to 0; index resets to 0 on start.
REQ-018 pix_rdy = 1 only in RUN.
REQ-019 Two line buffers of IMG_W x 16: each accepted pixel at column x is written to buffer B (line y-1 slot); the old B[x] moves to A (line y-2) in the same cycle.
REQ-020 On accept, row2_in=pix_in, row1_in=B[x], row0_in=A[x], all registered; pe_en=1 in the next cycle; otherwise pe_en=0 (pipeline stalls cleanly under pix_va gaps).
REQ-021 Column counter x wraps IMG_W-1 -> 0 and increments row counter y; the last-column and last-row boundaries occur in the same accept.
REQ-022 Tag pipeline of PE_LAT stages advances only on pe_en=1; tag=1 when x>=2 and y>=2 at accept.
REQ-023 feat_va=1, feat_out=map_out for one cycle when the tag exiting the pipeline is 1; exactly (IMG_W-2)*(IMG_H-2) features per frame.
REQ-024 DRAIN: pe_en=1 for PE_LAT cycles with row inputs 0 and tag 0.
REQ-025 frame_done=1 for one cycle in DONE; busy=1 in RUN and DRAIN.
REQ-026 Windows spanning a line boundary (x<2) and the first two lines are never reported.

Reset
REQ-027 On rst: state=IDLE; x, y, weight index, tags = 0; pix_rdy, pe_en, feat_va, frame_done, busy = 0; row*_in, feat_out, w00..w22 = 0.
REQ-028 rst mid-frame aborts immediately without frame_done; line buffer contents are don't-care.

Configuration
REQ-029 CONV_CTRL_RELU_EN defined: feat_out = 0 when map_out < 0, else map_out; undefined: feat_out = map_out unmodified.

Verification
REQ-030 IMG_W=IMG_H=4, all weights 1, all pixels 1, pix_va=1 -> 4 features, each value 9, then frame_done pulse.
REQ-031 Same frame with pix_va toggling 1/0 -> identical 4 values; pe_en high only on cycles after accepts.
REQ-032 Pixels 0..15 raster, w11=1, others 0 -> features 5,6,9,10.
REQ-033 w11=-1, pixels 1 -> feat_out -1 without CONV_CTRL_RELU_EN, 0 with it.
REQ-034 rst after 7 accepts, then new start -> full correct frame, no frame_done from aborted frame.
REQ-035 w_wr pulses while busy -> weights unchanged; start during RUN ignored.
